// File: rtl/tone_period_decoder_if.sv
// tone_period_decoder_if
//   Groups the tone decoder's data signals.
//   speaker      : square-wave input to be measured
//   period       : last accepted period in clk cycles (CNT_W bits)
//   period_valid : one-cycle pulse when period updates
//   locked       : tone stable
//   silent       : no tone present
//   master : the side that drives speaker and observes the results
//   slave  : the decoder itself
`timescale 1ns/1ps
interface tone_period_decoder_if #(
  parameter int CNT_W = 20
);
  logic             speaker;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             locked;
  logic             silent;

  modport master (output speaker, input period, period_valid, locked, silent);
  modport slave  (input speaker, output period, period_valid, locked, silent);
endinterface

// File: rtl/tone_period_decoder.sv
// tone_period_decoder
//   Measures the rising-edge-to-rising-edge period of an asynchronous
//   square wave in clk cycles, reports each measurement, and flags a
//   stable tone (locked) or the absence of a tone (silent).
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : tone_period_decoder_if slave modport (speaker in; period,
//           period_valid, locked, silent out). The interface instance
//           must be built with the same CNT_W as this module.
`timescale 1ns/1ps
module tone_period_decoder #(
  parameter int CNT_W      = 20,
  parameter int TIMEOUT    = 1_000_000,
  parameter int MIN_PERIOD = 16,
  parameter int TOL        = 2,
  parameter int STABLE     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  tone_period_decoder_if.slave bus
);

  localparam int MW = $clog2(STABLE + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] MIN_C     = CNT_W'(MIN_PERIOD);
  localparam logic [CNT_W-1:0] TOL_C     = CNT_W'(TOL);
  localparam logic [MW-1:0]    STABLE_C  = MW'(STABLE);

  typedef enum logic [1:0] {SILENT, ARM, TRACK} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] period_q, period_nxt;
  logic [CNT_W-1:0] diff;
  logic [MW-1:0]    match_cnt, match_nxt;
  logic             pv_q, pv_nxt;
  logic             locked_q, locked_nxt;
  logic             silent_q, silent_nxt;
  logic             sync1, sync2, sync3;
  logic             rise, accept, timed_out;

  // Two flops resolve metastability; the third remembers the previous
  // synchronized level for edge detection.
  // NOTE: non-blocking assignments make these a true shift chain; blocking
  // would collapse all three flops into one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.speaker;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign rise      = sync2 & ~sync3;
  // In SILENT any rise starts a measurement; otherwise edges too close to
  // the last accepted one are glitches.
  assign accept    = rise && ((state == SILENT) || (cnt >= MIN_C));
  assign timed_out = (cnt == TIMEOUT_C);
  assign diff      = (cnt >= period_q) ? (cnt - period_q) : (period_q - cnt);

  // NOTE: every signal written here gets a default first, so no path
  // leaves one unassigned and no latch is inferred.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = timed_out ? cnt : cnt + CNT_W'(1);
    period_nxt = period_q;
    pv_nxt     = 1'b0;
    match_nxt  = match_cnt;
    silent_nxt = silent_q;

    case (state)
      SILENT: begin
        if (accept) begin
          state_nxt = ARM;
          cnt_nxt   = CNT_W'(1);
        end
      end
      ARM, TRACK: begin
        if (accept) begin
          // cnt already equals the rise-to-rise distance (or TIMEOUT when
          // the rise lands on the timeout cycle).
          state_nxt  = TRACK;
          cnt_nxt    = CNT_W'(1);
          period_nxt = cnt;
          pv_nxt     = 1'b1;
          silent_nxt = 1'b0;
          if (state == ARM || diff > TOL_C)
            match_nxt = MW'(1);
          else if (match_cnt != STABLE_C)
            match_nxt = match_cnt + MW'(1);
        end else if (timed_out) begin
          state_nxt  = SILENT;
          silent_nxt = 1'b1;
          match_nxt  = '0;
        end
      end
      default: state_nxt = SILENT;
    endcase

    // Derived from the next match count so lock tracks the report it
    // belongs to in the same cycle.
    locked_nxt = (match_nxt >= STABLE_C);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= SILENT;
      cnt       <= '0;
      period_q  <= '0;
      pv_q      <= 1'b0;
      match_cnt <= '0;
      locked_q  <= 1'b0;
      silent_q  <= 1'b1;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      period_q  <= period_nxt;
      pv_q      <= pv_nxt;
      match_cnt <= match_nxt;
      locked_q  <= locked_nxt;
      silent_q  <= silent_nxt;
    end
  end

  assign bus.period       = period_q;
  assign bus.period_valid = pv_q;
  assign bus.locked       = locked_q;
  assign bus.silent       = silent_q;

endmodule
